i4003_loader: RTL and testbench

//  Parallel-to-serial driver for a chain of i4003 shift registers (CPU/port side of the SR link).

---
 rtl/i4003_pkg.sv | 17 +
 rtl/i4003_cp_timer.sv | 45 ++++
 rtl/i4003_loader.sv | 147 ++++++++++++++
 tb/tb_i4003_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i4003_pkg.sv
// Shared types and constants for the i4003 shift-register loader.
package i4003_pkg;

  localparam int unsigned I4003_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_e;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i4003_cp_timer.sv
// CP half-period timer: counts CLK_DIV cycles per phase and flags the last one.
// phase_end_o is registered and lines up with the final cycle of each phase.
module i4003_cp_timer
  import i4003_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic restart_i,
  input  logic run_i,
  output logic phase_end_o
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pe_q, pe_d;

  always_comb begin
    cnt_d = '0;
    pe_d  = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
      pe_d  = (LAST == '0);
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      pe_d  = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      pe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pe_q  <= pe_d;
    end
  end

  assign phase_end_o = pe_q;

endmodule

// File: rtl/i4003_loader.sv
// Parallel-to-serial driver for a chain of i4003 shift registers, MSB first.
// Optional readback of the previous chain contents via `define I4003_READBACK_EN.
module i4003_loader
  import i4003_pkg::*;
#(
  parameter int unsigned WIDTH   = I4003_WIDTH,
  parameter int unsigned CHAIN   = 1,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                   CLK_i,
  input  logic                   RST_N_i,
  input  logic [WIDTH*CHAIN-1:0] DATA_i,
  input  logic                   VALID_i,
  output logic                   READY_o,
  output logic                   CP_o,
  output logic                   DATA_OUT_o,
  output logic                   E_o,
  output logic                   BUSY_o,
  output logic                   DONE_o,
  input  logic                   SERIAL_IN_i,
  output logic [WIDTH*CHAIN-1:0] PREV_o
);

  localparam int unsigned NBITS = WIDTH * CHAIN;
  localparam int unsigned BCW   = $clog2(NBITS + 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             cp_q, cp_d;
  logic             dout_q, dout_d;
  logic             e_q, e_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;
  logic             accept;
  logic             last_bit;
  logic             shift_step;
  logic             finish;

  assign accept     = VALID_i & ready_q;
  assign last_bit   = (bitcnt_q == BCW'(NBITS - 1));
  assign shift_step = (state_q == SHIFT_HI) & phase_end;
  assign finish     = shift_step & last_bit;

  i4003_cp_timer #(.CLK_DIV(CLK_DIV)) u_cp_timer (
    .clk_i       (CLK_i),
    .rst_n_i     (RST_N_i),
    .restart_i   (accept),
    .run_i       (state_q != IDLE),
    .phase_end_o (phase_end)
  );

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept)    state_d = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_d = last_bit ? IDLE : SHIFT_LO;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath and output next values; outputs are a function of the next state so they register cleanly
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shreg_d  = DATA_i;
      bitcnt_d = '0;
    end else if (shift_step) begin
      shreg_d  = shreg_q << 1;
      bitcnt_d = bitcnt_q + BCW'(1);
    end
    cp_d    = (state_d == SHIFT_HI);
    dout_d  = (state_d == SHIFT_LO) ? shreg_d[NBITS-1] : dout_q;
    e_d     = finish ? 1'b1 : ((state_d != IDLE) ? 1'b0 : e_q);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = finish;
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cp_q     <= 1'b0;
      dout_q   <= 1'b0;
      e_q      <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cp_q     <= cp_d;
      dout_q   <= dout_d;
      e_q      <= e_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign READY_o    = ready_q;
  assign CP_o       = cp_q;
  assign DATA_OUT_o = dout_q;
  assign E_o        = e_q;
  assign BUSY_o     = busy_q;
  assign DONE_o     = done_q;

`ifdef I4003_READBACK_EN
  // The chain's serial output is stable at the end of SHIFT_LO, just before CP rises
  logic [NBITS-1:0] cap_q, cap_d;
  logic [NBITS-1:0] prev_q, prev_d;

  always_comb begin
    cap_d  = cap_q;
    prev_d = prev_q;
    if ((state_q == SHIFT_LO) && phase_end) cap_d = (cap_q << 1) | NBITS'(SERIAL_IN_i);
    if (finish) prev_d = cap_q;
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      cap_q  <= '0;
      prev_q <= '0;
    end else begin
      cap_q  <= cap_d;
      prev_q <= prev_d;
    end
  end

  assign PREV_o = prev_q;
`else
  logic unused_serial_in;
  assign unused_serial_in = SERIAL_IN_i;
  assign PREV_o           = '0;
`endif

endmodule

// File: tb/tb_i4003_loader.sv
// Bench for i4003_loader: cycle-level reference model plus attached i4003 chain models.
// Build with or without `define I4003_READBACK_EN.
module tb_i4003_loader;

  localparam int NA  = 10;
  localparam int CDA = 4;
  localparam int TA  = 2 * NA * CDA;
  localparam int NB  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1, valid = 1'b0;
  logic [NA-1:0] data = '0;
  logic          ready, cp, dout, e, busy, done, serial;
  logic [NA-1:0] prev;

  logic          rst_nb = 1'b1, valid_b = 1'b0;
  logic [NB-1:0] data_b = '0;
  logic          ready_b, cp_b, dout_b, e_b, busy_b, done_b, serial_b;
  logic [NB-1:0] prev_b;

  i4003_loader #(.WIDTH(NA), .CHAIN(1), .CLK_DIV(CDA)) dut_a (
    .CLK_i(clk), .RST_N_i(rst_n), .DATA_i(data), .VALID_i(valid), .READY_o(ready),
    .CP_o(cp), .DATA_OUT_o(dout), .E_o(e), .BUSY_o(busy), .DONE_o(done),
    .SERIAL_IN_i(serial), .PREV_o(prev));

  i4003_loader #(.WIDTH(10), .CHAIN(2), .CLK_DIV(1)) dut_b (
    .CLK_i(clk), .RST_N_i(rst_nb), .DATA_i(data_b), .VALID_i(valid_b), .READY_o(ready_b),
    .CP_o(cp_b), .DATA_OUT_o(dout_b), .E_o(e_b), .BUSY_o(busy_b), .DONE_o(done_b),
    .SERIAL_IN_i(serial_b), .PREV_o(prev_b));

  // i4003 chains: shift on CP rising, serial out is the MSB of the last device
  logic [NA-1:0] chain_a = 10'h155;
  logic [NB-1:0] chain_b = '0;
  int pulses_a = 0, pulses_b = 0, dones_a = 0;
  always @(posedge cp)   begin chain_a <= {chain_a[NA-2:0], dout};   pulses_a <= pulses_a + 1; end
  always @(posedge cp_b) begin chain_b <= {chain_b[NB-2:0], dout_b}; pulses_b <= pulses_b + 1; end
  assign serial   = chain_a[NA-1];
  assign serial_b = chain_b[NB-1];
  always @(negedge clk) if (done) dones_a <= dones_a + 1;

  int n_pass = 0, n_total = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: p = cycles since accept (0 = idle, TA+1 = done cycle)
  int            p = 0;
  logic [NA-1:0] w = '0, prev_exp = '0;
  logic          e_idle = 1'b0;
`ifdef I4003_READBACK_EN
  logic [NA-1:0] snap = '0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p        <= 0;
      e_idle   <= 1'b0;
      prev_exp <= '0;
    end else begin
      if ((p == 0 || p == TA + 1) && valid) begin
        p <= 1;
        w <= data;
`ifdef I4003_READBACK_EN
        snap <= chain_a;
`endif
      end else if (p >= 1 && p <= TA) p <= p + 1;
      else p <= 0;
      if (p == TA) begin
        e_idle <= 1'b1;
`ifdef I4003_READBACK_EN
        prev_exp <= snap;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (p == 0) begin
        check("READY_idle", ready, 1); check("BUSY_idle", busy, 0);
        check("CP_idle", cp, 0); check("DONE_idle", done, 0); check("E_idle", e, e_idle);
      end else if (p <= TA) begin
        check("READY_busy", ready, 0); check("BUSY_busy", busy, 1);
        check("CP_shift", cp, ((p - 1) / CDA) % 2);
        check("DATA_OUT", dout, w[NA - 1 - (p - 1) / (2 * CDA)]);
        check("E_busy", e, 0); check("DONE_busy", done, 0);
      end else begin
        check("READY_done", ready, 1); check("BUSY_done", busy, 0); check("CP_done", cp, 0);
        check("DONE_done", done, 1); check("E_done", e, 1); check("Q_at_done", chain_a, w);
      end
      check("PREV", prev, prev_exp);
    end
  end

  task automatic send_a(input logic [NA-1:0] wd, input bit wait_done, output int cyc);
    int g;
    g = 0;
    while (p != 0 && g < 1000) begin @(negedge clk); g++; end
    check("idle_wait", g < 1000, 1);
    @(posedge clk); #2 valid = 1'b1; data = wd;
    @(posedge clk); #2 valid = 1'b0; data = NA'($urandom);
    cyc = 0;
    if (wait_done) begin
      do begin @(negedge clk); cyc++; end while (!done && cyc < 300);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, ps, ds;
    #3 rst_n = 1'b0; rst_nb = 1'b0; cmp_en = 1'b1;
    #1;
    check("rst_READY", ready, 1); check("rst_CP", cp, 0); check("rst_DATA_OUT", dout, 0);
    check("rst_E", e, 0); check("rst_BUSY", busy, 0); check("rst_DONE", done, 0);
    check("rst_PREV", prev, 0); check("rst_b_READY", ready_b, 1); check("rst_b_E", e_b, 0);
    @(posedge clk); #2 rst_n = 1'b1; rst_nb = 1'b1;

    // Two-device chain, CLK_DIV=1, all ones
    ps = pulses_b;
    @(posedge clk); #2 valid_b = 1'b1; data_b = 20'hFFFFF;
    @(posedge clk); #2 valid_b = 1'b0; data_b = '0;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (busy_b) check("b_DATA_OUT", dout_b, 1);
    end while (!done_b && k < 200);
    check("b_done_cycle", k, 41); check("b_pulses", pulses_b - ps, 20);
    check("b_Q", chain_b, 20'hFFFFF); check("b_PREV", prev_b, 0);
    check("b_E_done", e_b, 1); check("b_READY_done", ready_b, 1); check("b_BUSY_done", busy_b, 0);
    @(negedge clk);
    check("b_DONE_pulse", done_b, 0); check("b_E_hold", e_b, 1);

    // Chain preloaded with 0x155, then load 0x0F0
    send_a(10'h0F0, 1'b1, k);
    check("Q_0F0", chain_a, 10'h0F0);
`ifdef I4003_READBACK_EN
    check("PREV_155", prev, 10'h155);
`else
    check("PREV_zero", prev, 0);
`endif

    // Default timing for 0x2A5
    ps = pulses_a;
    send_a(10'h2A5, 1'b1, k);
    check("done_cycle_2A5", k, 81); check("pulses_2A5", pulses_a - ps, 10);
    check("Q_2A5", chain_a, 10'h2A5);
`ifdef I4003_READBACK_EN
    check("PREV_0F0", prev, 10'h0F0);
`else
    check("PREV_zero2", prev, 0);
`endif

    // VALID held high with changing data across transfers
    @(posedge clk); #2 valid = 1'b1; data = 10'h3C3;
    repeat (2 * TA + 4) begin @(posedge clk); #2 data = NA'($urandom); end
    valid = 1'b0;

    // Asynchronous reset mid-transfer at cycle 30
    send_a(10'h1B6, 1'b0, k);
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_READY", ready, 1); check("mid_rst_CP", cp, 0); check("mid_rst_DATA_OUT", dout, 0);
    check("mid_rst_E", e, 0); check("mid_rst_BUSY", busy, 0); check("mid_rst_DONE", done, 0);
    check("mid_rst_PREV", prev, 0);
    ds = dones_a;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (120) @(negedge clk);
    check("no_done_after_rst", dones_a - ds, 0);
    send_a(10'h24B, 1'b1, k);
    check("done_cycle_restart", k, 81); check("Q_restart", chain_a, 10'h24B);

    // Random traffic
    repeat (3000) begin
      @(posedge clk); #2 valid = ($urandom_range(0, 7) == 0); data = NA'($urandom);
    end
    valid = 1'b0;
    repeat (TA + 10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
